wb_retire_stage: RTL and testbench

WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

---
 rtl/wb_retire_stage.sv | 145 ++++++++++++++
 tb/tb_wb_retire_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_stage.sv
// Writeback / retire stage.
// Holds the instruction leaving MEM for one cycle. From that register it
// presents the register-file write and the retiring memory access, and it
// tracks the halt, error and cycle/instruction counters.
module wb_retire_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [15:0]      mem_pc,
    input  logic [15:0]      mem_inst,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic             mem_memwrite,
    input  logic             mem_halt,
    input  logic [2:0]       mem_wreg,
    input  logic [15:0]      mem_alu_res,
    input  logic [15:0]      mem_rdata,
    input  logic [15:0]      mem_wdata,
    input  logic             stall,
    input  logic             flush,
    output logic             wb_valid,
    output logic [15:0]      wb_pc,
    output logic [15:0]      wb_inst,
    output logic             wb_regwrite,
    output logic [2:0]       wb_wreg,
    output logic [15:0]      wb_wdata,
    output logic             wb_memread,
    output logic             wb_memwrite,
    output logic [15:0]      wb_maddr,
    output logic [15:0]      wb_mdata,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic             err
);

    logic             validQ;
    logic             regwriteQ;
    logic             memtoregQ;
    logic             memwriteQ;
    logic             haltQ;
    logic [15:0]      pcQ;
    logic [15:0]      instQ;
    logic [2:0]       wregQ;
    logic [15:0]      wdataQ;
    logic [15:0]      maddrQ;
    logic [15:0]      mdataQ;
    logic             haltedQ;
    logic             errQ;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instCnt;

    logic retireEvt;
    logic captureEn;
    logic capMemtoreg;
    logic illegalCap;

    // Retire and capture qualifiers shared by the register and status logic.
    always_comb begin
        retireEvt   = validQ & ~stall;
        captureEn   = ~haltedQ & ~flush & ~stall;
        capMemtoreg = mem_valid & mem_memtoreg;
        illegalCap  = mem_valid & mem_memtoreg & mem_memwrite;
    end

    // WB pipeline register. Priority is reset, then halted/flush bubble, then stall hold, then capture.
    // Write data is muxed at capture, so only the selected 16-bit value is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ    <= 1'b0;
            regwriteQ <= 1'b0;
            memtoregQ <= 1'b0;
            memwriteQ <= 1'b0;
            haltQ     <= 1'b0;
            pcQ       <= '0;
            instQ     <= '0;
            wregQ     <= '0;
            wdataQ    <= '0;
            maddrQ    <= '0;
            mdataQ    <= '0;
        end else if (haltedQ || flush) begin
            validQ    <= 1'b0;
            regwriteQ <= 1'b0;
            memtoregQ <= 1'b0;
            memwriteQ <= 1'b0;
            haltQ     <= 1'b0;
        end else if (!stall) begin
            validQ    <= mem_valid;
            regwriteQ <= mem_valid & mem_regwrite;
            memtoregQ <= capMemtoreg;
            memwriteQ <= mem_valid & mem_memwrite;
            haltQ     <= mem_valid & mem_halt;
            pcQ       <= mem_pc;
            instQ     <= mem_inst;
            wregQ     <= mem_wreg;
            wdataQ    <= capMemtoreg ? mem_rdata : mem_alu_res;
            maddrQ    <= mem_alu_res;
            mdataQ    <= mem_wdata;
        end
    end

    // Counters, halt and error flags. All of this state is frozen once halted, until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            haltedQ  <= 1'b0;
            errQ     <= 1'b0;
            cycleCnt <= '0;
            instCnt  <= '0;
        end else if (!haltedQ) begin
            if (cycleCnt != '1) begin
                cycleCnt <= cycleCnt + CNT_W'(1);
            end
            if (retireEvt && (instCnt != '1)) begin
                instCnt <= instCnt + CNT_W'(1);
            end
            if (retireEvt && haltQ) begin
                haltedQ <= 1'b1;
            end
            if (captureEn && illegalCap) begin
                errQ <= 1'b1;
            end
        end
    end

    // Output mapping. The stored control bits are already gated by valid.
    always_comb begin
        wb_valid    = validQ;
        wb_pc       = pcQ;
        wb_inst     = instQ;
        wb_regwrite = regwriteQ;
        wb_wreg     = wregQ;
        wb_wdata    = wdataQ;
        wb_memread  = validQ & memtoregQ;
        wb_memwrite = memwriteQ;
        wb_maddr    = maddrQ;
        wb_mdata    = mdataQ;
        halted      = haltedQ;
        cycle_count = cycleCnt;
        inst_count  = instCnt;
        err         = errQ;
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage. A driver applies directed and random per-cycle
// inputs and pushes the expected post-edge state from a behavioural model.
// A monitor pops that expected state and compares it against two DUTs
// (CNT_W=32 and CNT_W=4) one time unit after every rising edge.
module tb_wb_retire_stage;

    typedef struct {
        logic        rst, valid, regwrite, memtoreg, memwrite, halt, stall, flush;
        logic [15:0] pc, inst, alu, rdata, wdata;
        logic [2:0]  wreg;
    } inT;

    typedef struct {
        logic        valid, regwrite, memtoreg, memwrite, halt, known;
        logic [15:0] pc, inst, alu, rdata, wdata;
        logic [2:0]  wreg;
    } slotT;

    typedef struct {
        slotT            s;
        logic            halted, err;
        longint unsigned cyc, ins;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, memValid = 1'b0, memRegwrite = 1'b0, memMemtoreg = 1'b0;
    logic        memMemwrite = 1'b0, memHalt = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] memPc = '0, memInst = '0, memAluRes = '0, memRdata = '0, memWdata = '0;
    logic [2:0]  memWreg = '0;

    logic        wbValid, wbRegwrite, wbMemread, wbMemwrite, halted, err;
    logic [15:0] wbPc, wbInst, wbWdata, wbMaddr, wbMdata;
    logic [2:0]  wbWreg;
    logic [31:0] cycleCount, instCount;

    logic        wbValid4, wbRegwrite4, wbMemread4, wbMemwrite4, halted4, err4;
    logic [15:0] wbPc4, wbInst4, wbWdata4, wbMaddr4, wbMdata4;
    logic [2:0]  wbWreg4;
    logic [3:0]  cycleCount4, instCount4;

    wb_retire_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(memValid), .mem_pc(memPc), .mem_inst(memInst),
        .mem_regwrite(memRegwrite), .mem_memtoreg(memMemtoreg), .mem_memwrite(memMemwrite),
        .mem_halt(memHalt), .mem_wreg(memWreg), .mem_alu_res(memAluRes), .mem_rdata(memRdata),
        .mem_wdata(memWdata), .stall(stall), .flush(flush),
        .wb_valid(wbValid), .wb_pc(wbPc), .wb_inst(wbInst), .wb_regwrite(wbRegwrite),
        .wb_wreg(wbWreg), .wb_wdata(wbWdata), .wb_memread(wbMemread), .wb_memwrite(wbMemwrite),
        .wb_maddr(wbMaddr), .wb_mdata(wbMdata), .halted(halted), .cycle_count(cycleCount),
        .inst_count(instCount), .err(err)
    );

    wb_retire_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_valid(memValid), .mem_pc(memPc), .mem_inst(memInst),
        .mem_regwrite(memRegwrite), .mem_memtoreg(memMemtoreg), .mem_memwrite(memMemwrite),
        .mem_halt(memHalt), .mem_wreg(memWreg), .mem_alu_res(memAluRes), .mem_rdata(memRdata),
        .mem_wdata(memWdata), .stall(stall), .flush(flush),
        .wb_valid(wbValid4), .wb_pc(wbPc4), .wb_inst(wbInst4), .wb_regwrite(wbRegwrite4),
        .wb_wreg(wbWreg4), .wb_wdata(wbWdata4), .wb_memread(wbMemread4), .wb_memwrite(wbMemwrite4),
        .wb_maddr(wbMaddr4), .wb_mdata(wbMdata4), .halted(halted4), .cycle_count(cycleCount4),
        .inst_count(instCount4), .err(err4)
    );

    expT expQ[$];
    int  nChecks = 0;
    int  nErrors = 0;
    int  nDriven = 0;
    int  nMonitored = 0;

    slotT            mSlot;
    logic            mHalted = 1'b0;
    logic            mErr = 1'b0;
    longint unsigned mCyc = 0;
    longint unsigned mIns = 0;

    function automatic logic [31:0] sat(input longint unsigned v, input int w);
        longint unsigned maxv = (64'd1 << w) - 64'd1;
        return 32'(v > maxv ? maxv : v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic inT idle();
        inT d;
        d = '{default: '0};
        return d;
    endfunction

    function automatic inT op(input logic [15:0] pc, input logic [2:0] wreg, input logic [15:0] alu);
        inT d;
        d = '{default: '0};
        d.valid = 1'b1;
        d.regwrite = 1'b1;
        d.pc = pc;
        d.inst = pc ^ 16'h5A00;
        d.wreg = wreg;
        d.alu = alu;
        d.rdata = ~alu;
        d.wdata = alu + 16'h0101;
        return d;
    endfunction

    // Reference model: one call per clock edge, computed from the stage rules.
    task automatic modelStep(input inT d);
        logic retireHalt;
        expT  e;
        if (d.rst) begin
            mSlot = '{default: '0};
            mSlot.known = 1'b1;
            mHalted = 1'b0;
            mErr = 1'b0;
            mCyc = 0;
            mIns = 0;
        end else if (mHalted) begin
            mSlot.valid = 0; mSlot.regwrite = 0; mSlot.memtoreg = 0;
            mSlot.memwrite = 0; mSlot.halt = 0; mSlot.known = 0;
        end else begin
            retireHalt = 1'b0;
            if (mSlot.valid && !d.stall) begin
                mIns++;
                retireHalt = mSlot.halt;
            end
            mCyc++;
            if (d.flush) begin
                mSlot.valid = 0; mSlot.regwrite = 0; mSlot.memtoreg = 0;
                mSlot.memwrite = 0; mSlot.halt = 0; mSlot.known = 0;
            end else if (!d.stall) begin
                mSlot.valid    = d.valid;
                mSlot.regwrite = d.valid && d.regwrite;
                mSlot.memtoreg = d.valid && d.memtoreg;
                mSlot.memwrite = d.valid && d.memwrite;
                mSlot.halt     = d.valid && d.halt;
                mSlot.pc = d.pc; mSlot.inst = d.inst; mSlot.wreg = d.wreg;
                mSlot.alu = d.alu; mSlot.rdata = d.rdata; mSlot.wdata = d.wdata;
                mSlot.known = 1'b1;
                if (d.valid && d.memtoreg && d.memwrite) mErr = 1'b1;
            end
            if (retireHalt) mHalted = 1'b1;
        end
        e.s = mSlot;
        e.halted = mHalted;
        e.err = mErr;
        e.cyc = mCyc;
        e.ins = mIns;
        expQ.push_back(e);
    endtask

    task automatic step(input inT d);
        @(negedge clk);
        rst = d.rst; memValid = d.valid; memPc = d.pc; memInst = d.inst;
        memRegwrite = d.regwrite; memMemtoreg = d.memtoreg; memMemwrite = d.memwrite;
        memHalt = d.halt; memWreg = d.wreg; memAluRes = d.alu; memRdata = d.rdata;
        memWdata = d.wdata; stall = d.stall; flush = d.flush;
        modelStep(d);
        nDriven++;
    endtask

    // Monitor: compare the DUT state after each edge against the next expected entry.
    initial begin
        expT         e;
        logic [15:0] expWdata;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nMonitored++;
                chk("wb_valid", 32'(wbValid), 32'(e.s.valid));
                chk("wb_regwrite", 32'(wbRegwrite), 32'(e.s.regwrite));
                chk("wb_memread", 32'(wbMemread), 32'(e.s.valid & e.s.memtoreg));
                chk("wb_memwrite", 32'(wbMemwrite), 32'(e.s.memwrite));
                chk("halted", 32'(halted), 32'(e.halted));
                chk("err", 32'(err), 32'(e.err));
                chk("cycle_count", cycleCount, sat(e.cyc, 32));
                chk("inst_count", instCount, sat(e.ins, 32));
                chk("cycle_count4", 32'(cycleCount4), sat(e.cyc, 4));
                chk("inst_count4", 32'(instCount4), sat(e.ins, 4));
                chk("halted4", 32'(halted4), 32'(e.halted));
                chk("err4", 32'(err4), 32'(e.err));
                chk("wb_valid4", 32'(wbValid4), 32'(e.s.valid));
                if (e.s.known) begin
                    expWdata = e.s.memtoreg ? e.s.rdata : e.s.alu;
                    chk("wb_pc", 32'(wbPc), 32'(e.s.pc));
                    chk("wb_inst", 32'(wbInst), 32'(e.s.inst));
                    chk("wb_wreg", 32'(wbWreg), 32'(e.s.wreg));
                    chk("wb_wdata", 32'(wbWdata), 32'(expWdata));
                    chk("wb_maddr", 32'(wbMaddr), 32'(e.s.alu));
                    chk("wb_mdata", 32'(wbMdata), 32'(e.s.wdata));
                end
            end
        end
    end

    initial begin
        inT d;
        mSlot = '{default: '0};

        d = idle(); d.rst = 1'b1;
        step(d); step(d);

        // ALU op, then a bubble
        d = op(16'h0010, 3'd3, 16'h1234);
        step(d);
        step(idle());
        step(idle());

        // load followed by store
        d = op(16'h0012, 3'd5, 16'h0040); d.memtoreg = 1'b1; d.rdata = 16'hBEEF;
        step(d);
        d = op(16'h0014, 3'd0, 16'h0050); d.regwrite = 1'b0; d.memwrite = 1'b1; d.wdata = 16'h00AA;
        step(d);
        step(idle());

        // valid instruction held for three stalled cycles while MEM changes
        step(op(16'h0016, 3'd2, 16'h7777));
        for (int i = 0; i < 3; i++) begin
            d = op(16'h0100 + 16'(i), 3'd6, 16'hAAAA); d.stall = 1'b1;
            step(d);
        end
        step(idle());
        // stall and flush together with a valid instruction in WB
        step(op(16'h0018, 3'd1, 16'h0001));
        d = op(16'h001A, 3'd4, 16'h0002); d.stall = 1'b1; d.flush = 1'b1;
        step(d);
        step(idle());

        // halt after five retirements, then inputs must be ignored
        d = idle(); d.rst = 1'b1;
        step(d);
        for (int i = 0; i < 5; i++) step(op(16'h0010 + 16'(2 * i), 3'(i), 16'(i * 3)));
        d = op(16'h0020, 3'd0, 16'h0000); d.regwrite = 1'b0; d.halt = 1'b1;
        step(d);
        for (int i = 0; i < 4; i++) begin
            d = op(16'h0030 + 16'(i), 3'd7, 16'hFFFF); d.memtoreg = 1'b1; d.memwrite = 1'b1;
            step(d);
        end
        d = idle(); d.rst = 1'b1;
        step(d);

        // halt retiring under stall waits for release
        d = op(16'h0040, 3'd0, 16'h0); d.halt = 1'b1;
        step(d);
        d = idle(); d.stall = 1'b1;
        step(d); step(d);
        step(idle());
        step(idle());
        d = idle(); d.rst = 1'b1;
        step(d);

        // twenty retirements saturate the 4-bit counters; illegal combination sets err
        for (int i = 0; i < 20; i++) step(op(16'(i), 3'(i), 16'(i + 100)));
        d = op(16'h0200, 3'd1, 16'h0300); d.memtoreg = 1'b1; d.memwrite = 1'b1;
        step(d);
        for (int i = 0; i < 3; i++) step(op(16'h0210 + 16'(i), 3'd2, 16'h0));
        d = idle(); d.rst = 1'b1;
        step(d);
        // illegal combination with mem_valid=0 must not set err
        d = idle(); d.memtoreg = 1'b1; d.memwrite = 1'b1;
        step(d);
        step(idle());

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d.rst      = ($urandom_range(0, 99) < 2);
            d.valid    = ($urandom_range(0, 99) < 70);
            d.regwrite = 1'($urandom);
            d.memtoreg = 1'($urandom);
            d.memwrite = ($urandom_range(0, 99) < 20);
            d.halt     = ($urandom_range(0, 99) < 3);
            d.stall    = ($urandom_range(0, 99) < 20);
            d.flush    = ($urandom_range(0, 99) < 10);
            d.pc       = 16'($urandom);
            d.inst     = 16'($urandom);
            d.alu      = 16'($urandom);
            d.rdata    = 16'($urandom);
            d.wdata    = 16'($urandom);
            d.wreg     = 3'($urandom);
            step(d);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        chk("monitor_count", 32'(nMonitored), 32'(nDriven));
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
